// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready output stream seen by the read-side adapter.
// The master is the adapter. The slave is the FIFO/consumer environment.
interface fifo_rd_stream_adapter_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_dout, m_ready,
        output fifo_rd, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_dout, m_ready,
        input  fifo_rd, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO controller.
// It issues rd pulses only when a word can be absorbed.
// A 2-entry skid buffer hides the FIFO's registered dout latency.
// Buffered words are presented as a valid/ready stream with a burst-last marker.
module fifo_rd_stream_adapter #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    fifo_rd_stream_adapter_if.master bus,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic                o_busy,
    output logic                o_err_underflow
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_occ;
    logic             r_pend;
    logic [BW-1:0]    r_beat;
    logic [DW-1:0]    r_data0, r_data1;
    logic             r_last0, r_last1;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_err;

    logic             w_pop;
    logic             w_push;
    logic             w_busy;
    logic             w_rd;
    logic             w_last_in;
    logic [2:0]       w_level;

    // Handshake, room check and burst-last decode for the word being pushed.
    always_comb begin
        w_pop     = (r_occ != 2'd0) & bus.m_ready;
        w_push    = r_pend;
        w_busy    = r_pend | (r_occ != 2'd0);
        // Occupancy after this cycle, counting the word already in flight.
        w_level   = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
        w_rd      = (r_state == RUN) & ~bus.fifo_empty & (w_level < 3'd2);
        w_last_in = (r_beat == BW'(BURST_LEN - 1));
    end

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Mode transitions: reads only in RUN, and DRAIN lets in-flight words finish.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_en) w_state_nxt = RUN;
            RUN:     if (!i_en) w_state_nxt = w_busy ? DRAIN : IDLE;
            DRAIN: begin
                if (i_en)        w_state_nxt = RUN;
                else if (!w_busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Track the outstanding read, whose data arrives on fifo_dout next cycle.
    always_ff @(posedge clk) begin
        if (rst) r_pend <= 1'b0;
        else     r_pend <= w_rd;
    end

    // Skid buffer: entry 0 is the head. Pushes land at the tail, and a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ   <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= bus.fifo_dout;
                        r_last0 <= w_last_in;
                    end else begin
                        r_data1 <= bus.fifo_dout;
                        r_last1 <= w_last_in;
                    end
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data0 <= bus.fifo_dout;
                        r_last0 <= w_last_in;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= bus.fifo_dout;
                        r_last1 <= w_last_in;
                    end
                end
                default: ;
            endcase
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Burst position advances per pushed word, not per pop, so en gaps never shift it.
    always_ff @(posedge clk) begin
        if (rst)         r_beat <= '0;
        else if (w_push) r_beat <= w_last_in ? '0 : r_beat + 1'b1;
    end

    // Delivered-word counter, which wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)        r_word_cnt <= '0;
        else if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                     r_err <= 1'b0;
        else if (bus.fifo_underflow) r_err <= 1'b1;
    end

    assign bus.fifo_rd      = w_rd;
    assign bus.m_valid      = (r_occ != 2'd0);
    assign bus.m_data       = r_data0;
    assign bus.m_last       = r_last0;
    assign o_word_cnt       = r_word_cnt;
    assign o_busy           = w_busy;
    assign o_err_underflow  = r_err;

    // A push into a full buffer without a same-cycle pop would lose a word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_pend && !w_pop && (r_occ == 2'd2)));
    a_occ_range: assert property (@(posedge clk) disable iff (rst) r_occ != 2'd3);
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench: a behavioural 16-deep FIFO feeds the adapter.
// Every word written is queued with its expected burst-last flag.
// A negedge monitor pops and compares each delivered word.
module tb_fifo_rd_stream_adapter;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [CW-1:0] word_cnt;
    logic          busy;
    logic          err;

    fifo_rd_stream_adapter_if #(.DW(DW)) bus();

    fifo_rd_stream_adapter #(.DW(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (en),
        .bus             (bus),
        .o_word_cnt      (word_cnt),
        .o_busy          (busy),
        .o_err_underflow (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [DW-1:0] mem [16];
    int            wp = 0, rp = 0, fcount = 0;
    logic          wr = 1'b0;
    logic [DW-1:0] wd = '0;

    assign bus.fifo_empty = (fcount == 0);

    always @(posedge clk) begin : fifo_model
        bit w_ok, r_ok;
        w_ok = wr && (fcount < 16);
        r_ok = bus.fifo_rd && (fcount > 0);
        if (rst) begin
            wp <= 0; rp <= 0; fcount <= 0; bus.fifo_dout <= '0;
        end else begin
            if (w_ok) begin mem[wp] <= wd; wp <= (wp + 1) % 16; end
            if (r_ok) begin bus.fifo_dout <= mem[rp]; rp <= (rp + 1) % 16; end
            fcount <= fcount + int'(w_ok) - int'(r_ok);
        end
    end

    // Scoreboard: {last, data} in write order; last follows the word index within a burst.
    logic [DW:0] exp_q[$];
    int          burst_idx = 0;
    int          pops = 0;
    int          rd_cnt = 0;
    int          exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic put_word(input logic [DW-1:0] d);
        int n = 0;
        while (fcount >= 16 && n < 200) begin step(); n++; end
        chk("fifo_space_wait", 32'(n < 200), 32'd1);
        wr = 1'b1; wd = d;
        exp_q.push_back({(burst_idx == BL - 1), d});
        burst_idx = (burst_idx + 1) % BL;
        step();
        wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        en = 1'b1; bus.m_ready = 1'b1;
        while (!(exp_q.size() == 0 && fcount == 0 && !busy) && n < 500) begin step(); n++; end
        chk("drain_done", 32'(n < 500), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    32'(bus.fifo_rd), 32'd0);
        chk({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.m_data),  32'd0);
        chk({tag, "_last"},  32'(bus.m_last),  32'd0);
        chk({tag, "_cnt"},   32'(word_cnt),    32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_err"},   32'(err),         32'd0);
    endtask

    // Count read strobes actually taken by the FIFO.
    initial forever begin
        @(posedge clk);
        if (!rst && bus.fifo_rd) rd_cnt++;
    end

    // Monitor
    initial begin : monitor
        bit            hold = 1'b0;
        logic [DW-1:0] hd;
        logic          hl;
        logic [DW:0]   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                exp_cnt = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(bus.m_valid), 32'd1);
                    chk("hold_data",  32'(bus.m_data),  32'(hd));
                    chk("hold_last",  32'(bus.m_last),  32'(hl));
                end
                chk("word_cnt", 32'(word_cnt), 32'(exp_cnt[CW-1:0]));
                if (bus.fifo_rd) chk("rd_while_empty", 32'(bus.fifo_empty), 32'd0);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word got=%0h want=none", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 32'(bus.m_data), 32'(e[DW-1:0]));
                        chk("m_last", 32'(bus.m_last), 32'(e[DW]));
                    end
                    pops++;
                    exp_cnt++;
                end
                hold = bus.m_valid && !bus.m_ready;
                hd = bus.m_data;
                hl = bus.m_last;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rd, base_p, n, written;
        bit found;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Three words, free-flowing consumer.
        put_word(8'hA1); put_word(8'hA2); put_word(8'hA3);
        drain();
        chk("t1_word_cnt", 32'(word_cnt), 32'd3);
        chk("t1_busy", 32'(busy), 32'd0);

        // Backpressure: only two reads may be outstanding, then release with no gaps.
        en = 1'b0; bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) put_word(8'(8'h20 + i));
        base_rd = rd_cnt; base_p = pops;
        en = 1'b1;
        repeat (12) step();
        chk("bp_rd_pulses", 32'(rd_cnt - base_rd), 32'd2);
        chk("bp_no_pop", 32'(pops - base_p), 32'd0);
        chk("bp_head", 32'(bus.m_data), 32'h20);
        bus.m_ready = 1'b1;
        repeat (10) step();
        chk("bp_no_gap", 32'(pops - base_p), 32'd10);
        drain();
        chk("bp_fifo_empty", 32'(bus.fifo_empty), 32'd1);

        // Randomized traffic: stalls, en toggles and sparse writes.
        written = 0;
        while (written < 40) begin
            bus.m_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 4) != 0);
            if (fcount < 15 && $urandom_range(0, 1) == 1) begin
                wr = 1'b1;
                wd = (written < 8) ? 8'(8'h10 + written) : 8'($urandom);
                exp_q.push_back({(burst_idx == BL - 1), wd});
                burst_idx = (burst_idx + 1) % BL;
                written++;
            end
            step();
            wr = 1'b0;
        end
        drain();

        // Empty FIFO with en high: no reads; then the sticky underflow flag.
        en = 1'b1;
        base_rd = rd_cnt;
        repeat (20) step();
        chk("empty_no_rd", 32'(rd_cnt - base_rd), 32'd0);
        chk("empty_err0", 32'(err), 32'd0);
        bus.fifo_underflow = 1'b1; step(); bus.fifo_underflow = 1'b0; step();
        chk("uf_set", 32'(err), 32'd1);
        repeat (5) step();
        chk("uf_sticky", 32'(err), 32'd1);

        // Drop en in the cycle of the 3rd read: exactly three words, then resume.
        en = 1'b0; bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) put_word(8'(8'h40 + i));
        base_rd = rd_cnt; base_p = pops;
        en = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            if (bus.fifo_rd && (rd_cnt - base_rd) == 2) begin en = 1'b0; found = 1'b1; end
            n++;
        end
        chk("en_drop_seen", 32'(found), 32'd1);
        step();
        repeat (8) step();
        chk("en_drop_rds", 32'(rd_cnt - base_rd), 32'd3);
        chk("en_drop_pops", 32'(pops - base_p), 32'd3);
        chk("en_drop_busy", 32'(busy), 32'd0);
        drain();
        chk("en_resume_pops", 32'(pops - base_p), 32'd6);

        // Reset with a word buffered and a read in flight.
        en = 1'b0; bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) put_word(8'(8'h60 + i));
        base_rd = rd_cnt;
        en = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            if (bus.fifo_rd && (rd_cnt - base_rd) == 1) found = 1'b1;
            n++;
        end
        chk("rst_rd_seen", 32'(found), 32'd1);
        step();
        rst = 1'b1;
        exp_q.delete();
        burst_idx = 0;
        step();
        chk_reset_outputs("rst1");
        rst = 1'b0;
        base_p = pops;
        bus.m_ready = 1'b1;
        repeat (6) step();
        chk("rst_no_stray", 32'(pops - base_p), 32'd0);
        put_word(8'h55);
        drain();
        chk("rst_fresh_pops", 32'(pops - base_p), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
